// File: rtl/time_disp_pkg.sv
// Shared constants and types for the scanned 6-digit time display.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package time_disp_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [9:0] MINS_MAX  = 10'd59;
    localparam logic [9:0] SECS_MAX  = 10'd59;
    localparam logic [9:0] HOURS_MAX = 10'd12;
    localparam logic [9:0] MSECS_MAX = 10'd999;

    typedef logic [2:0] digit_idx_t;
    localparam digit_idx_t DIGIT_LAST = 3'd5;

    typedef enum logic {VIEW_CLOCK = 1'b0, VIEW_SW = 1'b1} view_t;

    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_DASH;
        endcase
    endfunction

    function automatic logic [6:0] field_glyph(input logic oor, input logic [3:0] d);
        return oor ? SEG_DASH : digit_glyph(d);
    endfunction

endpackage

// File: rtl/time_display_mux_bin2bcd3.sv
// Combinational 10-bit binary to 3 BCD digits, flagging values above MAX_VAL.
module bin2bcd3
    import time_disp_pkg::*;
#(
    parameter logic [9:0] MAX_VAL = MSECS_MAX
) (
    input  logic [9:0] bin,
    output logic [3:0] hund,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       oor
);

    assign hund  = 4'(bin / 10'd100);
    assign tens  = 4'((bin / 10'd10) % 10'd10);
    assign units = 4'(bin % 10'd10);
    assign oor   = bin > MAX_VAL;

endmodule

// File: rtl/time_display_mux.sv
// Scanned 6-digit 7-segment driver: per-frame snapshot of the time bus, BCD conversion, digit mux, alarm blink.
// Optional LEAD_ZERO_BLANK_EN: blank the leading hours digit in clock view when Hours < 10.
module time_display_mux
    import time_disp_pkg::*;
#(
    parameter int SCAN_DIV     = 20,
    parameter int BLINK_FRAMES = 21
) (
    input  logic       Clock_5K,
    input  logic       Reset,
    input  logic       Control,
    input  logic [3:0] Hours,
    input  logic [5:0] Mins,
    input  logic [5:0] Secs,
    input  logic [9:0] MSecs,
    input  logic       AM_PM,
    input  logic       Alarm,
    input  logic       SW_State,
    output logic [6:0] Seg,
    output logic       DP,
    output logic [5:0] Digit_En,
    output logic       PM_LED,
    output logic       Alarm_LED,
    output logic       SW_LED
);

    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

`ifdef LEAD_ZERO_BLANK_EN
    localparam bit LEAD_BLANK = 1'b1;
`else
    localparam bit LEAD_BLANK = 1'b0;
`endif

    logic [SCAN_W-1:0]  scan_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;
    digit_idx_t         digit_idx;
    logic               first_cyc;

    view_t      snap_view;
    logic [3:0] snap_hours;
    logic [5:0] snap_mins;
    logic [5:0] snap_secs;
    logic [9:0] snap_msecs;

    logic       scan_tc, frame_wrap, blink_tc;
    logic [6:0] nxt_seg;
    logic       nxt_dp;

    logic [3:0] h_hund, h_tens, h_units, m_hund, m_tens, m_units;
    logic [3:0] s_hund, s_tens, s_units, ms_hund, ms_tens, ms_units;
    logic       h_oor, m_oor, s_oor, ms_oor, hours_oor;
    logic       unused_bits;

    bin2bcd3 #(.MAX_VAL(HOURS_MAX)) u_hours (.bin({6'd0, snap_hours}), .hund(h_hund),  .tens(h_tens),  .units(h_units),  .oor(h_oor));
    bin2bcd3 #(.MAX_VAL(MINS_MAX))  u_mins  (.bin({4'd0, snap_mins}),  .hund(m_hund),  .tens(m_tens),  .units(m_units),  .oor(m_oor));
    bin2bcd3 #(.MAX_VAL(SECS_MAX))  u_secs  (.bin({4'd0, snap_secs}),  .hund(s_hund),  .tens(s_tens),  .units(s_units),  .oor(s_oor));
    bin2bcd3 #(.MAX_VAL(MSECS_MAX)) u_msecs (.bin(snap_msecs),         .hund(ms_hund), .tens(ms_tens), .units(ms_units), .oor(ms_oor));

    assign unused_bits = ^{h_hund, m_hund, s_hund, ms_units};
    assign hours_oor   = h_oor | (snap_hours == 4'd0);

    assign scan_tc    = scan_cnt == SCAN_W'(SCAN_DIV - 1);
    assign frame_wrap = scan_tc && (digit_idx == DIGIT_LAST);
    assign blink_tc   = blink_cnt == BLINK_W'(BLINK_FRAMES - 1);

    always_comb begin
        nxt_seg = SEG_BLANK;
        nxt_dp  = 1'b1;
        if (snap_view == VIEW_CLOCK) begin
            case (digit_idx)
                3'd0: nxt_seg = (!hours_oor && LEAD_BLANK && h_tens == 4'd0) ? SEG_BLANK
                                                                            : field_glyph(hours_oor, h_tens);
                3'd1: begin nxt_seg = field_glyph(hours_oor, h_units); nxt_dp = 1'b0; end
                3'd2: nxt_seg = field_glyph(m_oor, m_tens);
                3'd3: begin nxt_seg = field_glyph(m_oor, m_units); nxt_dp = 1'b0; end
                3'd4: nxt_seg = field_glyph(s_oor, s_tens);
                3'd5: nxt_seg = field_glyph(s_oor, s_units);
                default: ;
            endcase
        end else begin
            case (digit_idx)
                3'd0: nxt_seg = field_glyph(m_oor, m_tens);
                3'd1: begin nxt_seg = field_glyph(m_oor, m_units); nxt_dp = 1'b0; end
                3'd2: nxt_seg = field_glyph(s_oor, s_tens);
                3'd3: begin nxt_seg = field_glyph(s_oor, s_units); nxt_dp = 1'b0; end
                3'd4: nxt_seg = field_glyph(ms_oor, ms_hund);
                3'd5: nxt_seg = field_glyph(ms_oor, ms_tens);
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clock_5K) begin
        if (Reset) begin
            scan_cnt    <= '0;
            digit_idx   <= '0;
            first_cyc   <= 1'b1;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            snap_view   <= VIEW_CLOCK;
            snap_hours  <= '0;
            snap_mins   <= '0;
            snap_secs   <= '0;
            snap_msecs  <= '0;
            PM_LED      <= 1'b0;
            Alarm_LED   <= 1'b0;
            SW_LED      <= 1'b0;
            Seg         <= SEG_BLANK;
            DP          <= 1'b1;
            Digit_En    <= 6'h3F;
        end else begin
            scan_cnt  <= scan_tc ? '0 : scan_cnt + 1'b1;
            first_cyc <= 1'b0;
            if (scan_tc)
                digit_idx <= (digit_idx == DIGIT_LAST) ? '0 : digit_idx + 3'd1;

            // The whole bus is frozen for a frame so a digit pair can never tear.
            if (first_cyc || frame_wrap) begin
                snap_view  <= view_t'(Control);
                snap_hours <= Hours;
                snap_mins  <= Mins;
                snap_secs  <= Secs;
                snap_msecs <= MSecs;
                PM_LED     <= AM_PM;
                Alarm_LED  <= Alarm;
                SW_LED     <= SW_State;
            end

            if (!Alarm_LED) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
            end else if (frame_wrap) begin
                if (blink_tc) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end

            Seg      <= nxt_seg;
            DP       <= nxt_dp;
            Digit_En <= blink_phase ? 6'h3F : ~(6'b000001 << digit_idx);
        end
    end

endmodule
